// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned.
// The core issues start, stalls on busy, and takes results when done pulses.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [CW-1:0]    cnt;

  // Working registers: partial remainder, dividend/quotient shift register,
  // divisor magnitude, and the raw dividend kept for the divide-by-zero result.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] orig_a;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Operand magnitudes; the most negative value maps to unsigned 2^(WIDTH-1).
  always_comb begin
    a_neg = op_signed & dividend[WIDTH-1];
    b_neg = op_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor  : divisor;
  end

  // One restoring step. The shifted remainder is WIDTH+1 bits; when its top
  // bit is set it always exceeds the divisor, and the true difference is then
  // below the divisor, so a WIDTH-bit wrap-around subtract gives it exactly.
  always_comb begin
    shifted = {acc, dq[WIDTH-1]};
    low     = shifted[WIDTH-1:0];
    ge      = shifted[WIDTH] | (low >= dvs);
    diff    = low - dvs;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in CALC, correct and publish in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      dq          <= '0;
      dvs         <= '0;
      orig_a      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt    <= CW'(WIDTH - 1);
      acc    <= '0;
      dq     <= a_mag;
      dvs    <= b_mag;
      orig_a <= dividend;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz     <= (divisor == '0);
    end else if (state == CALC) begin
      acc <= ge ? diff : low;
      dq  <= {dq[WIDTH-2:0], ge};
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      if (dz) begin
        quotient    <= '1;
        remainder   <= orig_a;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= neg_q ? -dq  : dq;
        remainder   <= neg_r ? -acc : acc;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_signed   (op_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divider's special cases.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Issue one division and wait (bounded) for done. lat counts clock edges
  // from the accepting edge (=1) to the edge after which done is seen.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input bit aligned, input int inject,
                     output int lat, output int bcnt);
    if (!aligned) @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; op_signed = s;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == inject) begin
        start = 1'b1; dividend = ~a; divisor = 32'd3; op_signed = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  vec_t vecs[10];
  int   lat, bcnt, ndone;
  logic [31:0] mq, mr;
  logic        mz;
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
    vecs[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5] = '{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6] = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0};
    vecs[7] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[8] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[9] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};

    // Reset state.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors with latency and busy-duration checks.
    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, 0, lat, bcnt);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd34);
      check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd33);
      check($sformatf("vec%0d_q", i), quotient, vecs[i].eq);
      check($sformatf("vec%0d_r", i), remainder, vecs[i].er);
      check($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].ez));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Back-to-back: start asserted during the DONE cycle.
    run(32'd100, 32'd7, 1'b0, 1'b0, 0, lat, bcnt);
    check("b2b_first_q", quotient, 32'd14);
    run(32'd20, 32'd6, 1'b0, 1'b1, 0, lat, bcnt);
    check("b2b_lat", 32'(lat), 32'd34);
    check("b2b_q", quotient, 32'd3);
    check("b2b_r", remainder, 32'd2);

    // Start pulse with new operands while busy is ignored.
    run(32'd1000, 32'd7, 1'b0, 1'b0, 5, lat, bcnt);
    check("ign_lat", 32'(lat), 32'd34);
    check("ign_busy", 32'(bcnt), 32'd33);
    check("ign_q", quotient, 32'd142);
    check("ign_r", remainder, 32'd6);
    @(posedge clk); #1;
    check("ign_no_second_op", 32'(busy), 32'd0);

    // Reset asserted in the 10th CALC cycle aborts immediately.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; op_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    run(32'd1000, 32'd10, 1'b0, 1'b0, 0, lat, bcnt);
    check("post_rst_lat", 32'(lat), 32'd34);
    check("post_rst_q", quotient, 32'd100);
    check("post_rst_r", remainder, 32'd0);

    // Results hold through idle cycles even with operand inputs moving.
    for (int c = 0; c < 50; c++) begin
      dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      check("hold_q", quotient, 32'd100);
      check("hold_r", remainder, 32'd0);
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 250; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 255));
        3:       rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
        4:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        5:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(ra, rb, rs, mq, mr, mz);
      run(ra, rb, rs, 1'b0, 0, lat, bcnt);
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'd34);
      check($sformatf("rnd%0d_q %h/%h s%0d", n, ra, rb, rs), quotient, mq);
      check($sformatf("rnd%0d_r %h/%h s%0d", n, ra, rb, rs), remainder, mr);
      check($sformatf("rnd%0d_dz", n), 32'(div_by_zero), 32'(mz));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
